// File: rtl/avalon_mem_responder_if.sv
// rtl/avalon_mem_responder_if.sv - Avalon-MM data/instruction bus between CPU master and memory responder

interface avalon_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// rtl/avalon_mem_responder.sv - Avalon-MM slave RAM with waitrequest latency, byte lanes and preload port
// Optional request-stability checker enabled by defining AVALON_PROTOCOL_CHECK_EN.

module avalon_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    avalon_mem_responder_if.slave       bus,
    input  logic                        load_en,
    input  logic [7:0]                  load_addr,
    input  logic [31:0]                 load_data,
    output logic                        proto_err
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] WAIT_32    = WAIT_CYCLES;
    localparam logic [3:0]  WAIT_LOAD  = WAIT_32[3:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ACK
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        req;
    logic [31:0] byte_off;
    logic [31:0] word_off;
    logic        in_range;
    logic [IDX_W-1:0] bus_idx;
    logic [31:0] load_word;
    logic        load_in_range;
    logic [IDX_W-1:0] load_idx;
    logic        ack_live;
    logic        commit;

    assign req       = bus.read | bus.write;
    assign byte_off  = bus.address - BASE_ADDR;
    assign word_off  = {2'b00, byte_off[31:2]};
    assign in_range  = (bus.address >= BASE_ADDR) && (word_off < DEPTH_WORDS);
    assign bus_idx   = word_off[IDX_W-1:0];

    assign load_word     = {26'd0, load_addr[7:2]};
    assign load_in_range = load_word < DEPTH_WORDS;
    assign load_idx      = load_word[IDX_W-1:0];

    // A preload freezes the handshake, so an ACK only counts once load_en is low.
    assign ack_live = (state_q == ST_ACK) && !load_en;
    assign commit   = ack_live && bus.write && in_range;

    assign bus.waitrequest = load_en | (req & (state_q != ST_ACK));
    assign bus.readdata    = (ack_live && bus.read && !bus.write && in_range) ? mem_q[bus_idx] : 32'h0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!load_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_d = ST_ACK;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = ST_BUSY;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!req) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_q <= 4'd1) begin
                        state_d = ST_ACK;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory is deliberately left out of reset so a reset does not wipe a loaded program.
    always_ff @(posedge clk) begin
        if (load_en) begin
            if (load_in_range) begin
                mem_q[load_idx] <= load_data;
            end
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    mem_q[bus_idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

`ifdef AVALON_PROTOCOL_CHECK_EN
    logic [31:0] addr_lat_q;
    logic        read_lat_q;
    logic        write_lat_q;
    logic [31:0] wdata_lat_q;
    logic [3:0]  be_lat_q;
    logic        proto_err_q;
    logic        req_start;
    logic        req_changed;

    assign req_start   = (state_q == ST_IDLE) && req && !load_en;
    assign req_changed = (bus.address    != addr_lat_q)  ||
                         (bus.read       != read_lat_q)  ||
                         (bus.write      != write_lat_q) ||
                         (bus.writedata  != wdata_lat_q) ||
                         (bus.byteenable != be_lat_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_lat_q  <= 32'h0;
            read_lat_q  <= 1'b0;
            write_lat_q <= 1'b0;
            wdata_lat_q <= 32'h0;
            be_lat_q    <= 4'h0;
            proto_err_q <= 1'b0;
        end else begin
            if (req_start) begin
                addr_lat_q  <= bus.address;
                read_lat_q  <= bus.read;
                write_lat_q <= bus.write;
                wdata_lat_q <= bus.writedata;
                be_lat_q    <= bus.byteenable;
            end
            // Abandoning in BUSY drops read/write, which the comparison already catches.
            if ((state_q != ST_IDLE) && req_changed) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: doc/avalon_mem_responder.md
Name: avalon_mem_responder

Overview:
- Avalon-MM slave memory: the responder end of the CPU's data/instruction bus master.
- Word-organised RAM with a parameterised waitrequest latency, byte-lane writes, and a side preload port so benches can load programs before releasing the CPU.
- Replaces ad-hoc bench RAM models; sits directly on the CPU's address, read, write, writedata, byteenable, readdata and waitrequest signals.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; byte address range 0 to 4*DEPTH_WORDS-1.
- BASE_ADDR, 32'h00000000, bus byte address mapped to word 0.
- WAIT_CYCLES, 1, extra BUSY cycles per transfer (0..15).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  32  byte address from master; bits [1:0] ignored.
- read  input  1  read request.
- write  input  1  write request.
- writedata  input  32  write data.
- byteenable  input  4  lane enables; bit0 = writedata[7:0] ... bit3 = writedata[31:24].
- readdata  output  32  read data; valid in the cycle waitrequest is low during a read.
- waitrequest  output  1  stall; the master holds all request signals while high.
- load_en  input  1  preload strobe.
- load_addr  input  8  preload byte address; bits [1:0] ignored.
- load_data  input  32  preload word; the full word is written.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, readdata=0, proto_err=0. Memory contents are not cleared.
- FSM states: IDLE, BUSY, ACK.
- waitrequest = (read|write) && state!=ACK, combinational. Also forced high while load_en=1.
- IDLE:
  - read|write sampled high and load_en=0: go to BUSY with counter=WAIT_CYCLES.
  - If WAIT_CYCLES=0, go straight to ACK.
- BUSY: decrement counter each cycle; go to ACK when the counter reaches 1 (or 0).
- ACK:
  - waitrequest=0.
  - Read: readdata = mem[word] during this cycle.
  - Write: enabled lanes are committed at the rising edge ending ACK.
  - Next state is always IDLE.
- Timing: every transfer costs 1+WAIT_CYCLES stall cycles plus 1 ACK cycle. Back-to-back requests have one IDLE cycle between them, with waitrequest high in that cycle.
- Word index = (address-BASE_ADDR)>>2.
- Out of range (address<BASE_ADDR or index>=DEPTH_WORDS): reads return 32'h0, writes are dropped. The handshake completes normally.
- read and write both high: treated as a write; readdata=0 in ACK.
- readdata outside a read ACK: holds 32'h0.
- Preload:
  - load_en=1 writes load_data to mem[load_addr>>2] at the clock edge.
  - The FSM freezes in its current state (counter held) while load_en=1.
  - If frozen in ACK, the ACK is deferred and waitrequest is high.
- Master drops read/write while in BUSY: return to IDLE next cycle, no write committed.
- Reset asserted mid-transfer: go to IDLE immediately, nothing committed. If read or write is still high after reset release, a new transfer starts.

Optional Feature:
- Macro: AVALON_PROTOCOL_CHECK_EN.
- Defined:
  - In BUSY or ACK, a change of address, read, write, writedata or byteenable versus the values latched at request start sets proto_err=1.
  - Abandoning a request in BUSY also sets proto_err=1.
  - proto_err is sticky until reset.
- Undefined: proto_err is tied to 0 and no latch registers are built.

Test Plan:
- Preload mem[0x04]=32'h2403F0F0 via the load port, WAIT_CYCLES=1; read address 0x04 → waitrequest high for 2 cycles, then readdata=32'h2403F0F0 in the ACK cycle.
- Write 32'hDEADBEEF with byteenable=4'b0101 to 0x10 (initially 32'h11223344); read back → 32'h11AD33EF.
- Read address 0x400 with DEPTH_WORDS=256 → readdata=0, handshake completes. Write 32'hFFFFFFFF to 0x400, then read 0x0 → mem[0] unchanged.
- WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 → each has exactly 1 stall cycle and 1 ACK cycle, with one IDLE gap.
- Assert reset in BUSY during a write of 32'hCAFEF00D to 0x8 → waitrequest reasserts after release, old data 32'h0 remains, readdata=0.
- With AVALON_PROTOCOL_CHECK_EN: change address during BUSY → proto_err=1 and stays 1 until reset. Without the macro, the same stimulus leaves proto_err=0.
